round_arbiter: RTL

Round-robin arbiter and one-stage pipeline for the shared posit round/sticky datapath of the PPU. It takes up to NREQ concurrent rounding jobs from the add/sub, mul and div result paths over valid/ready handshakes. It grants one job per cycle and registers the resulting round_bit/sticky_bit with the requester tag. The downstream posit encoder consumes the result over a valid/ready output port.

---
 rtl/ppu_pkg.sv | 40 ++++
 rtl/round_arbiter_round_sticky_core.sv | 38 +++
 rtl/round_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared posit widths and the rounding job record for the round/sticky datapath
package ppu_pkg;
   localparam int PPU_N  = 16;
   localparam int PPU_ES = 1;
   // ES=0 still carries a 1-bit exponent field so port widths never collapse to zero
   localparam int NO_ES_FIELD = 0;

   function automatic int s_bits(input int n);
      return $clog2(n);
   endfunction

   function automatic int mant_size(input int n);
      return n - 2;
   endfunction

   function automatic int mant_len_bits(input int n);
      return $clog2(n) + 2;
   endfunction

   function automatic int frac_full_size(input int n);
      return 3 * mant_size(n) + 2;
   endfunction

   function automatic int k_bits(input int n);
      return $clog2(n) + 2;
   endfunction

   function automatic int exp_bits(input int es);
      return (es == NO_ES_FIELD) ? 1 : es;
   endfunction

   typedef struct packed {
      logic [mant_len_bits(PPU_N)-1:0]  frac_len;
      logic [frac_full_size(PPU_N)-1:0] frac_full;
      logic [s_bits(PPU_N)+1:0]         frac_len_diff;
      logic [k_bits(PPU_N)-1:0]         k;
      logic [exp_bits(PPU_ES)-1:0]      exp;
      logic                             frac_truncated;
   } round_job_t;
endpackage

// File: rtl/round_arbiter_round_sticky_core.sv
// round_sticky_core: combinational round/sticky bit extraction for one rounding job
module round_sticky_core import ppu_pkg::*; #(
   parameter int N  = 16,
   parameter int ES = 1,
   localparam int ML = mant_len_bits(N),
   localparam int FF = frac_full_size(N),
   localparam int DW = s_bits(N) + 2,
   localparam int KB = k_bits(N),
   localparam int EW = exp_bits(ES)
) (
   input  logic [ML-1:0] frac_len_i,
   input  logic [FF-1:0] frac_full_i,
   input  logic [DW-1:0] frac_len_diff_i,
   input  logic [KB-1:0] k_i,
   input  logic [EW-1:0] exp_i,
   input  logic          frac_truncated_i,
   output logic          round_o,
   output logic          sticky_o
);
   localparam logic [KB-1:0] K_HI = KB'(N - 2 - ES);
   localparam logic [KB-1:0] K_LO = KB'(-(N - 2));

   logic [FF-1:0] mask;
   logic          neg, exp_nz, rb_pos, st_pos, rb_neg;

   // a zero-length drop means nothing lies below the cut, so round and mask are both empty
   assign mask   = (frac_len_diff_i == '0) ? '0 : ((FF'(1) << (frac_len_diff_i - 1'b1)) - FF'(1));
   assign rb_pos = (frac_len_diff_i == '0) ? 1'b0 : frac_full_i[frac_len_diff_i - 1'b1];
   assign st_pos = (|(frac_full_i & mask)) | frac_truncated_i;
   assign neg    = frac_len_i[ML-1];
   assign exp_nz = |exp_i;
   // negative fraction length only rounds up at the regime extremes
   assign rb_neg = (ES == 0)     ? 1'b0 :
                   (k_i == K_HI) ? (exp_nz && |frac_full_i) :
                   (k_i == K_LO) ? exp_nz : 1'b0;
   assign round_o  = neg ? rb_neg : rb_pos;
   assign sticky_o = neg ? 1'b0 : st_pos;
endmodule

// File: rtl/round_arbiter.sv
// round_arbiter: round-robin grant of rounding jobs into a one-stage round/sticky result register
module round_arbiter import ppu_pkg::*; #(
   parameter int N    = 16,
   parameter int ES   = 1,
   parameter int NREQ = 2,
   localparam int TAG_W = $clog2(NREQ),
   localparam int ML    = mant_len_bits(N),
   localparam int FF    = frac_full_size(N),
   localparam int DW    = s_bits(N) + 2,
   localparam int KB    = k_bits(N),
   localparam int EW    = exp_bits(ES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic [NREQ*ML-1:0]   req_frac_len_i,
   input  logic [NREQ*FF-1:0]   req_frac_full_i,
   input  logic [NREQ*DW-1:0]   req_frac_len_diff_i,
   input  logic [NREQ*KB-1:0]   req_k_i,
   input  logic [NREQ*EW-1:0]   req_exp_i,
   input  logic [NREQ-1:0]      req_frac_truncated_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [TAG_W-1:0]     out_tag_o,
   output logic                 out_round_bit_o,
   output logic                 out_sticky_bit_o,
   output logic [15:0]          jobs_done_o
);
   logic [TAG_W-1:0] last_q, last_d, tag_q, tag_d, gnt;
   logic             out_valid_q, out_valid_d, round_q, round_d, sticky_q, sticky_d;
   logic [15:0]      jobs_q, jobs_d;
   logic             any, free, accept, rb, sb;
   int               idx;

   // scan downward so the nearest valid requester after the last grant wins
   always_comb begin
      gnt = last_q;
      any = 1'b0;
      idx = 0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last_q) + i) % NREQ;
         if (req_valid_i[idx]) begin
            gnt = TAG_W'(idx);
            any = 1'b1;
         end
      end
   end

   assign free        = !out_valid_q || out_ready_i;
   assign accept      = any && free && !rst;
   assign req_ready_o = accept ? (NREQ'(1) << gnt) : '0;

   round_sticky_core #(.N(N), .ES(ES)) u_core (
      .frac_len_i       (req_frac_len_i[int'(gnt)*ML +: ML]),
      .frac_full_i      (req_frac_full_i[int'(gnt)*FF +: FF]),
      .frac_len_diff_i  (req_frac_len_diff_i[int'(gnt)*DW +: DW]),
      .k_i              (req_k_i[int'(gnt)*KB +: KB]),
      .exp_i            (req_exp_i[int'(gnt)*EW +: EW]),
      .frac_truncated_i (req_frac_truncated_i[gnt]),
      .round_o          (rb),
      .sticky_o         (sb)
   );

   // load on accept, clear on drain, otherwise hold; count every output transfer
   always_comb begin
      out_valid_d = accept ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
      tag_d       = accept ? gnt : tag_q;
      round_d     = accept ? rb : round_q;
      sticky_d    = accept ? sb : sticky_q;
      last_d      = accept ? gnt : last_q;
      jobs_d      = (out_valid_q && out_ready_i) ? jobs_q + 16'd1 : jobs_q;
   end

   // state registers; pointer resets to the top index so requester 0 goes first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         tag_q       <= '0;
         round_q     <= 1'b0;
         sticky_q    <= 1'b0;
         last_q      <= TAG_W'(NREQ - 1);
         jobs_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         tag_q       <= tag_d;
         round_q     <= round_d;
         sticky_q    <= sticky_d;
         last_q      <= last_d;
         jobs_q      <= jobs_d;
      end
   end

   assign out_valid_o      = out_valid_q;
   assign out_tag_o        = tag_q;
   assign out_round_bit_o  = round_q;
   assign out_sticky_bit_o = sticky_q;
   assign jobs_done_o      = jobs_q;
endmodule
